pong_game_ctrl: RTL
===================

Name: pong_game_ctrl

Overview:
- Game-flow sequencer for the Pong datapath. It sits between the VGA frame tick, the player buttons, the ball block and the paddle blocks.
- Decides when paddles and ball may move, when the ball is re-centred, and which way it is served.
- Keeps both scores and declares a winner.
- All timing is counted in frames, using the one-cycle refresh_tick pulse that fires once per frame.

Parameters:
- WIN_SCORE, 7, points needed to win; legal range 1..15.
- SERVE_FRAMES, 60, frames the ball is held centred before launch; must be >= 1.
- POINT_FRAMES, 90, frames the game is frozen after a point; must be >= 1.

Ports:
- clk  in  1  pixel clock (25 MHz domain).
- reset  in  1  asynchronous, active-low reset.
- refresh_tick  in  1  one-cycle pulse, once per frame.
- start  in  1  raw start button, asynchronous.
- pause  in  1  raw pause button, asynchronous; used only with PAUSE_EN.
- miss_left  in  1  level; ball has passed player 1's goal line.
- miss_right  in  1  level; ball has passed player 2's goal line.
- paddle_en  out  1  paddles may move.
- ball_en  out  1  ball may move.
- ball_rst  out  1  hold the ball at centre.
- serve_dir  out  1  launch direction: 0 = toward player 1 (left), 1 = toward player 2 (right).
- score1  out  4  player 1 score.
- score2  out  4  player 2 score.
- game_over  out  1  a player has won.
- winner  out  2  0 = none, 1 = player 1, 2 = player 2.
- state_o  out  3  current state encoding, for debug and pixel_gen overlays.

Behaviour:
- Reset (reset=0, asynchronous):
  - state IDLE, score1=score2=0, frame_cnt=0.
  - paddle_en=0, ball_en=0, ball_rst=1, serve_dir=1, game_over=0, winner=0.
- start and pause each pass through a 2-flop synchronizer plus rising-edge detect, giving a one-cycle pulse (start_p / pause_p). The pulse appears 3 clk cycles after the input rises.
- All outputs are registered and change on the clk edge after the triggering condition.
- IDLE: ball_rst=1, all enables 0. start_p -> SERVE, clearing scores, frame_cnt and setting serve_dir=1.
- SERVE: paddle_en=1, ball_en=0, ball_rst=1.
  - frame_cnt increments on each refresh_tick.
  - On the tick where frame_cnt==SERVE_FRAMES-1: go to PLAY, frame_cnt=0.
- PLAY: paddle_en=1, ball_en=1, ball_rst=0.
  - miss_left=1: score2+1, serve_dir=0.
  - miss_right=1: score1+1, serve_dir=1.
  - If both are high in the same cycle, miss_left wins and only one point is awarded.
  - After scoring: if the new score == WIN_SCORE -> OVER, else -> POINT.
  - A miss is acted on in the cycle it is seen, not gated by refresh_tick.
- POINT: all enables 0, ball_rst=1. Count refresh_ticks; on the tick where frame_cnt==POINT_FRAMES-1 -> SERVE, frame_cnt=0.
- OVER: game_over=1, winner=1 or 2, all enables 0, ball_rst=1. start_p -> SERVE with scores cleared, winner=0, serve_dir=1.
- start_p in SERVE, PLAY or POINT is ignored.
- Scores never exceed WIN_SCORE; increments are 4-bit and never wrap.
- frame_cnt width is $clog2(max(SERVE_FRAMES, POINT_FRAMES)+1). The counter is cleared on every state entry.
- miss inputs are ignored outside PLAY.
- A reset assertion in any state returns to the reset values immediately (asynchronously).

Optional Feature:
- Macro: PONG_PAUSE_EN.
- Defined:
  - pause_p in SERVE or PLAY -> PAUSED, saving the origin state.
  - In PAUSED: all enables 0, ball_rst held at its pre-pause value, frame_cnt frozen, misses ignored.
  - Next pause_p returns to the saved state with frame_cnt unchanged.
  - pause_p in IDLE, POINT or OVER is ignored.
- Undefined: the pause port is present but unused, PAUSED is unreachable, and no synchronizer is built for pause.

Decomposition:
- Shared package pong_pkg holds:
  - the state enum: IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4, PAUSED=5;
  - SCORE_W=4;
  - the winner encodings.
- One sub-module: btn_sync_edge (2-flop synchronizer plus rising-edge pulse), instantiated once for start and once for pause.

Test Plan:
All scenarios use WIN_SCORE=3, SERVE_FRAMES=2, POINT_FRAMES=3, with refresh_tick every 10 cycles.
1. Reset, then raise start -> start_p 3 cycles later; state SERVE; after 2 ticks state PLAY with ball_en=1, ball_rst=0, serve_dir=1.
2. In PLAY, pulse miss_right -> score1=1, serve_dir=1, state POINT, enables 0; after 3 ticks state SERVE; after 2 more ticks state PLAY.
3. miss_left and miss_right high together in PLAY -> only score2 increments, serve_dir=0.
4. Three miss_left events -> score2=3, game_over=1, winner=2, state OVER. Further misses leave scores unchanged. start -> SERVE with scores 0 and winner 0.
5. Assert reset mid-PLAY with score1=2 -> outputs return to reset values asynchronously, without waiting for a clk edge.
6. With PONG_PAUSE_EN: pause in SERVE after 1 tick -> PAUSED, with 5 ticks ignored; pause again -> SERVE, and PLAY follows after exactly 1 more tick.

Source files
------------

// File: rtl/pong_pkg.sv
// pong_pkg: shared state encoding, score width and winner codes for the Pong game controller.
package pong_pkg;
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SERVE  = 3'd1,
      PLAY   = 3'd2,
      POINT  = 3'd3,
      OVER   = 3'd4,
      PAUSED = 3'd5
   } state_t;
   localparam int SCORE_W = 4;
   localparam logic [1:0] WIN_NONE = 2'd0;
   localparam logic [1:0] WIN_P1   = 2'd1;
   localparam logic [1:0] WIN_P2   = 2'd2;
endpackage

// File: rtl/pong_game_ctrl_btn_sync_edge.sv
// btn_sync_edge: 2-flop synchronizer plus registered rising-edge detect; pulse is high 3 clk edges after btn rises.
module btn_sync_edge (
   input  logic clk,
   input  logic reset,
   input  logic btn,
   output logic pulse
);
   logic [2:0] sh;
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         sh    <= '0;
         pulse <= 1'b0;
      end else begin
         sh    <= {sh[1:0], btn};
         pulse <= sh[1] & ~sh[2];
      end
endmodule

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: Pong game-flow sequencer (serve, play, point freeze, scoring, winner).
// Defining PONG_PAUSE_EN adds a PAUSED state driven by the pause button.
module pong_game_ctrl
   import pong_pkg::*;
#(
   parameter int WIN_SCORE    = 7,
   parameter int SERVE_FRAMES = 60,
   parameter int POINT_FRAMES = 90
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               refresh_tick,
   input  logic               start,
   input  logic               pause,
   input  logic               miss_left,
   input  logic               miss_right,
   output logic               paddle_en,
   output logic               ball_en,
   output logic               ball_rst,
   output logic               serve_dir,
   output logic [SCORE_W-1:0] score1,
   output logic [SCORE_W-1:0] score2,
   output logic               game_over,
   output logic [1:0]         winner,
   output logic [2:0]         state_o
);
   localparam int MAX_F = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
   localparam int FW = $clog2(MAX_F + 1);
   localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_SCORE);
   localparam logic [FW-1:0] SERVE_LAST = FW'(SERVE_FRAMES - 1);
   localparam logic [FW-1:0] POINT_LAST = FW'(POINT_FRAMES - 1);
   state_t state, state_n;
   logic [FW-1:0] cnt, cnt_n;
   logic [SCORE_W-1:0] s1_n, s2_n;
   logic dir_n;
   logic [1:0] win_n;
   logic start_p, pause_p;

   btn_sync_edge u_start (.clk(clk), .reset(reset), .btn(start), .pulse(start_p));
`ifdef PONG_PAUSE_EN
   state_t saved, saved_n;
   btn_sync_edge u_pause (.clk(clk), .reset(reset), .btn(pause), .pulse(pause_p));
   always_ff @(posedge clk or negedge reset)
      if (!reset) saved <= IDLE;
      else saved <= saved_n;
`else
   logic unused_pause;
   assign unused_pause = pause;
   assign pause_p = 1'b0;
`endif

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      s1_n    = score1;
      s2_n    = score2;
      dir_n   = serve_dir;
      win_n   = winner;
`ifdef PONG_PAUSE_EN
      saved_n = saved;
      if (pause_p && (state == SERVE || state == PLAY)) begin
         saved_n = state;
         state_n = PAUSED;
      end else
`endif
      case (state)
         IDLE, OVER: if (start_p) begin
            state_n = SERVE;
            cnt_n   = '0;
            s1_n    = '0;
            s2_n    = '0;
            dir_n   = 1'b1;
            win_n   = WIN_NONE;
         end
         SERVE: if (refresh_tick) begin
            state_n = (cnt == SERVE_LAST) ? PLAY : SERVE;
            cnt_n   = (cnt == SERVE_LAST) ? '0 : cnt + 1'b1;
         end
         PLAY: if (miss_left || miss_right) begin
            // miss_left has priority: a double miss awards only player 2
            if (miss_left) begin
               s2_n  = score2 + 1'b1;
               dir_n = 1'b0;
            end else begin
               s1_n  = score1 + 1'b1;
               dir_n = 1'b1;
            end
            state_n = (s1_n == WIN || s2_n == WIN) ? OVER : POINT;
            win_n   = (s2_n == WIN) ? WIN_P2 : (s1_n == WIN) ? WIN_P1 : WIN_NONE;
            cnt_n   = '0;
         end
         POINT: if (refresh_tick) begin
            state_n = (cnt == POINT_LAST) ? SERVE : POINT;
            cnt_n   = (cnt == POINT_LAST) ? '0 : cnt + 1'b1;
         end
`ifdef PONG_PAUSE_EN
         PAUSED: state_n = pause_p ? saved : PAUSED;
`endif
         default: begin
            state_n = IDLE;
            cnt_n   = '0;
         end
      endcase
   end

   // Outputs are registered from the next state so they move on the same edge as the state.
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state     <= IDLE;
         cnt       <= '0;
         score1    <= '0;
         score2    <= '0;
         serve_dir <= 1'b1;
         winner    <= WIN_NONE;
         paddle_en <= 1'b0;
         ball_en   <= 1'b0;
         ball_rst  <= 1'b1;
         game_over <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         score1    <= s1_n;
         score2    <= s2_n;
         serve_dir <= dir_n;
         winner    <= win_n;
         paddle_en <= (state_n == SERVE) || (state_n == PLAY);
         ball_en   <= (state_n == PLAY);
         ball_rst  <= (state_n == PAUSED) ? ball_rst : (state_n != PLAY);
         game_over <= (state_n == OVER);
      end

   assign state_o = state;
endmodule
